// File: rtl/dm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_ctrl
// Brief    : Data-memory responder. It owns the data RAM and handles byte-lane
//            stores, registered loads and misalignment faults. Defining
//            DM_STALL_EN adds the RD_WAIT load wait-state FSM.
// Revision : 1.0 - initial release
// ============================================================================
module dm_ctrl #(
    parameter int DM_AW   = 12,
    parameter int RD_WAIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dmce,
    input  logic             dmwe,
    input  logic [DM_AW-1:0] dmaddr,
    input  logic [3:0]       dmbytesel,
    input  logic [31:0]      dmdin,
    output logic [31:0]      dmdout,
    output logic             dmstall,
    output logic             dmfault
);

    localparam int c_depth = 2 ** (DM_AW - 2);

    logic [31:0]      r_mem [c_depth];
    logic [31:0]      r_dout;
    logic             r_fault;

    logic [DM_AW-3:0] w_idx;
    logic [1:0]       w_off;
    logic [3:0]       w_sel;
    logic             w_aligned;
    logic [3:0]       w_lanes;
    logic [31:0]      w_wdata;
    logic [31:0]      w_rdata;
    logic [31:0]      w_shift;
    logic             w_accept;

    assign w_idx = dmaddr[DM_AW-1:2];
    assign w_off = dmaddr[1:0];

    // Unrecognised width codes are treated as full-word accesses.
    always_comb begin
        w_sel     = 4'b1111;
        w_aligned = (w_off == 2'b00);
        case (dmbytesel)
            4'b0011: begin
                w_sel     = 4'b0011;
                w_aligned = ~w_off[0];
            end
            4'b0001: begin
                w_sel     = 4'b0001;
                w_aligned = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_lanes  = w_sel << w_off;
    assign w_wdata  = dmdin << {w_off, 3'b000};
    assign w_shift  = r_mem[w_idx] >> {w_off, 3'b000};
    assign w_rdata  = w_shift & {{8{w_sel[3]}}, {8{w_sel[2]}}, {8{w_sel[1]}}, {8{w_sel[0]}}};
    assign w_accept = dmce & ~dmstall;

`ifdef DM_STALL_EN
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] c_wait_m1 = 4'(RD_WAIT - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       w_stall;

    // Stall is gated by rst so an asynchronous reset releases the initiator at once.
    always_comb begin
        w_stall = 1'b0;
        if (!rst && (RD_WAIT != 0)) begin
            case (r_state)
                S_IDLE:  w_stall = dmce & ~dmwe & w_aligned;
                S_WAIT:  w_stall = dmce & (r_cnt != 4'd0);
                default: w_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_stall) begin
                        r_state <= S_WAIT;
                        r_cnt   <= c_wait_m1;
                    end
                end
                S_WAIT: begin
                    if (!dmce || (r_cnt == 4'd0)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dmstall = w_stall;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (RD_WAIT > 0);
    assign dmstall      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout  <= 32'd0;
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_accept & ~w_aligned;
            if (w_accept && !dmwe) begin
                r_dout <= w_aligned ? w_rdata : 32'd0;
            end
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_accept && dmwe && w_aligned) begin
            for (int b = 0; b < 4; b++) begin
                if (w_lanes[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign dmdout  = r_dout;
    assign dmfault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_dm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_ctrl
// Brief    : Scoreboard bench for dm_ctrl using directed loads and stores with
//            hand-computed results. Wait-state cases apply when DM_STALL_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_ctrl;

    localparam int DM_AW   = 12;
    localparam int RD_WAIT = 2;

    logic             clk;
    logic             rst;
    logic             dmce;
    logic             dmwe;
    logic [DM_AW-1:0] dmaddr;
    logic [3:0]       dmbytesel;
    logic [31:0]      dmdin;
    logic [31:0]      dmdout;
    logic             dmstall;
    logic             dmfault;

    typedef struct {
        logic        is_load;
        logic [31:0] dout;
        logic        fault;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic acc_pend = 1'b0;

    dm_ctrl #(.DM_AW(DM_AW), .RD_WAIT(RD_WAIT)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .dmce      (dmce),
        .dmwe      (dmwe),
        .dmaddr    (dmaddr),
        .dmbytesel (dmbytesel),
        .dmdin     (dmdin),
        .dmdout    (dmdout),
        .dmstall   (dmstall),
        .dmfault   (dmfault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: an accept seen before an edge is checked just after that edge.
    always @(negedge clk) acc_pend = dmce && !dmstall && !rst;

    always @(posedge clk) begin
        exp_t e;
        if (acc_pend) begin
            #1;
            if (q.size() == 0) begin
                chk("unexpected_accept", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("fault", {31'd0, dmfault}, {31'd0, e.fault});
                if (e.is_load) chk("load_data", dmdout, e.dout);
            end
        end else if (!rst) begin
            #1;
            chk("fault_idle", {31'd0, dmfault}, 32'd0);
        end
    end

    task automatic drive(input logic we, input logic [11:0] a, input logic [3:0] sel,
                         input logic [31:0] d);
        dmce      = 1'b1;
        dmwe      = we;
        dmaddr    = a;
        dmbytesel = sel;
        dmdin     = d;
    endtask

    task automatic req(input logic we, input logic [11:0] a, input logic [3:0] sel,
                       input logic [31:0] d, input logic [31:0] exp_dout, input logic exp_fault);
        bit done;
        q.push_back('{is_load: ~we, dout: exp_dout, fault: exp_fault});
        @(posedge clk);
        #1 drive(we, a, sel, d);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!dmstall) done = 1'b1;
        end
        if (!done) begin
            chk("accept_timeout", 32'd0, 32'd1);
            void'(q.pop_back());
            dmce = 1'b0;
        end else begin
            @(posedge clk);
            #1 dmce = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0; dmce = 1'b0; dmwe = 1'b0;
        dmaddr = '0; dmbytesel = 4'b0000; dmdin = '0;

        // Power-on reset applied asynchronously mid-cycle.
        #2 rst = 1'b1;
        #1;
        chk("rst_dout",  dmdout,            32'd0);
        chk("rst_stall", {31'd0, dmstall},  32'd0);
        chk("rst_fault", {31'd0, dmfault},  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Byte-lane merge into a word.
        req(1'b1, 12'h010, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
        req(1'b1, 12'h012, 4'b0001, 32'h0000005A, 32'h0, 1'b0);
        req(1'b0, 12'h010, 4'b1111, 32'h0,        32'hDE5ABEEF, 1'b0);
        req(1'b0, 12'h012, 4'b0011, 32'h0,        32'h0000DE5A, 1'b0);
        req(1'b0, 12'h013, 4'b0001, 32'h0,        32'h000000DE, 1'b0);
        req(1'b0, 12'h010, 4'b0001, 32'h0,        32'h000000EF, 1'b0);
        req(1'b0, 12'h010, 4'b0011, 32'h0,        32'h0000BEEF, 1'b0);

        // Misaligned accesses fault, return zero, and leave RAM alone.
        req(1'b0, 12'h011, 4'b1111, 32'h0,        32'h0, 1'b1);
        req(1'b1, 12'h013, 4'b0011, 32'h0000FFFF, 32'h0, 1'b1);
        req(1'b0, 12'h011, 4'b0011, 32'h0,        32'h0, 1'b1);
        req(1'b0, 12'h010, 4'b1111, 32'h0,        32'hDE5ABEEF, 1'b0);

        // Upper half-word store, unknown width code, and top-of-memory byte.
        req(1'b1, 12'h014, 4'b1111, 32'h00000000, 32'h0, 1'b0);
        req(1'b1, 12'h016, 4'b0011, 32'h00001234, 32'h0, 1'b0);
        req(1'b0, 12'h014, 4'b1111, 32'h0,        32'h12340000, 1'b0);
        req(1'b1, 12'h018, 4'b0101, 32'hCAFEF00D, 32'h0, 1'b0);
        req(1'b0, 12'h018, 4'b1111, 32'h0,        32'hCAFEF00D, 1'b0);
        req(1'b1, 12'hFFF, 4'b0001, 32'h00000077, 32'h0, 1'b0);
        req(1'b0, 12'hFFF, 4'b0001, 32'h0,        32'h00000077, 1'b0);
        req(1'b0, 12'h010, 4'b1111, 32'h0,        32'hDE5ABEEF, 1'b0);

        // Mid-cycle reset clears outputs; RAM survives.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_dout",  dmdout,           32'd0);
        chk("midrst_stall", {31'd0, dmstall}, 32'd0);
        chk("midrst_fault", {31'd0, dmfault}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req(1'b0, 12'h010, 4'b1111, 32'h0, 32'hDE5ABEEF, 1'b0);

`ifdef DM_STALL_EN
        // Load pays RD_WAIT stall cycles; a store right after it does not.
        q.push_back('{is_load: 1'b1, dout: 32'hDE5ABEEF, fault: 1'b0});
        @(posedge clk);
        #1 drive(1'b0, 12'h010, 4'b1111, 32'h0);
        @(negedge clk); chk("stall_t0", {31'd0, dmstall}, 32'd1);
        @(negedge clk); chk("stall_t1", {31'd0, dmstall}, 32'd1);
        @(negedge clk); chk("stall_t2", {31'd0, dmstall}, 32'd0);
        @(posedge clk);
        #1 drive(1'b1, 12'h01C, 4'b1111, 32'h11223344);
        q.push_back('{is_load: 1'b0, dout: 32'h0, fault: 1'b0});
        @(negedge clk); chk("store_nostall", {31'd0, dmstall}, 32'd0);
        @(posedge clk);
        #1 dmce = 1'b0;
        req(1'b0, 12'h01C, 4'b1111, 32'h0, 32'h11223344, 1'b0);

        // Reset while waiting: stall drops instantly; a reissued load completes.
        @(posedge clk);
        #1 drive(1'b0, 12'h010, 4'b1111, 32'h0);
        @(negedge clk); chk("stall_pre_rst", {31'd0, dmstall}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("waitrst_stall", {31'd0, dmstall}, 32'd0);
        chk("waitrst_dout",  dmdout,           32'd0);
        @(negedge clk);
        rst  = 1'b0;
        dmce = 1'b0;
        req(1'b0, 12'h010, 4'b1111, 32'h0, 32'hDE5ABEEF, 1'b0);
`else
        // Without wait states a load never stalls.
        q.push_back('{is_load: 1'b1, dout: 32'h12340000, fault: 1'b0});
        @(posedge clk);
        #1 drive(1'b0, 12'h014, 4'b1111, 32'h0);
        @(negedge clk); chk("load_nostall", {31'd0, dmstall}, 32'd0);
        @(posedge clk);
        #1 dmce = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
